// File: rtl/branch_seq_ctrl.sv
// EX-stage branch sequencing controller: captures one branch, drives the comparator,
// redirects fetch through a valid/ready handshake and holds a flush/stall window.
module branch_seq_ctrl #(
    parameter int unsigned WORD         = 32,
    parameter int unsigned OPCODE_LEN   = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [OPCODE_LEN-1:0] br_opcode,
    input  logic [WORD-1:0]       br_rs0,
    input  logic [WORD-1:0]       br_rs1,
    input  logic [WORD-1:0]       br_pc,
    input  logic [WORD-1:0]       br_offs,

    output logic [OPCODE_LEN-1:0] cmp_opcode,
    output logic [WORD-1:0]       cmp_in0,
    output logic [WORD-1:0]       cmp_in1,
    output logic [WORD-1:0]       cmp_pc_in,
    output logic [WORD-1:0]       cmp_offs_in,
    input  logic                  cmp_out,
    input  logic [WORD-1:0]       cmp_pc_out,

    output logic                  redirect_valid,
    output logic [WORD-1:0]       redirect_pc,
    input  logic                  redirect_ready,

    output logic                  flush,
    output logic                  stall,
    output logic                  br_ale,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      taken_cnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EVAL     = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    localparam int unsigned       FCNT_W     = 4;
    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    logic [1:0]            state_q,  state_d;
    logic [OPCODE_LEN-1:0] op_q,     op_d;
    logic [WORD-1:0]       rs0_q,    rs0_d;
    logic [WORD-1:0]       rs1_q,    rs1_d;
    logic [WORD-1:0]       pc_q,     pc_d;
    logic [WORD-1:0]       offs_q,   offs_d;
    logic [WORD-1:0]       rpc_q,    rpc_d;
    logic [FCNT_W-1:0]     fcnt_q,   fcnt_d;
    logic [CNT_W-1:0]      bcnt_q,   bcnt_d;
    logic [CNT_W-1:0]      tcnt_q,   tcnt_d;
    logic                  rv_q,     rv_d;
    logic                  flush_q,  flush_d;
    logic                  stall_q,  stall_d;
    logic                  ready_q,  ready_d;
    logic                  ale_q,    ale_d;

    // Next-state, capture, statistics and registered-output decode
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs0_d   = rs0_q;
        rs1_d   = rs1_q;
        pc_d    = pc_q;
        offs_d  = offs_q;
        rpc_d   = rpc_q;
        fcnt_d  = fcnt_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        ale_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    op_d    = br_opcode;
                    rs0_d   = br_rs0;
                    rs1_d   = br_rs1;
                    pc_d    = br_pc;
                    offs_d  = br_offs;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (bcnt_q != CNT_MAX) begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
                if (!cmp_out) begin
                    state_d = S_IDLE;
                end else if (cmp_pc_out[1:0] != 2'b00) begin
                    // Misaligned target raises an exception instead of redirecting
                    ale_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (tcnt_q != CNT_MAX) begin
                        tcnt_d = tcnt_q + CNT_W'(1);
                    end
                    rpc_d   = cmp_pc_out;
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (rv_q && redirect_ready) begin
                    fcnt_d  = FLUSH_LOAD;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                fcnt_d = fcnt_q - FCNT_W'(1);
                if (fcnt_q <= FCNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered versions of the upcoming state's decode
        ready_d = (state_d == S_IDLE);
        rv_d    = (state_d == S_REDIRECT);
        flush_d = (state_d == S_REDIRECT) || (state_d == S_FLUSH);
        stall_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rs0_q   <= '0;
            rs1_q   <= '0;
            pc_q    <= '0;
            offs_q  <= '0;
            rpc_q   <= '0;
            fcnt_q  <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            rv_q    <= 1'b0;
            flush_q <= 1'b0;
            stall_q <= 1'b0;
            ready_q <= 1'b1;
            ale_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs0_q   <= rs0_d;
            rs1_q   <= rs1_d;
            pc_q    <= pc_d;
            offs_q  <= offs_d;
            rpc_q   <= rpc_d;
            fcnt_q  <= fcnt_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            rv_q    <= rv_d;
            flush_q <= flush_d;
            stall_q <= stall_d;
            ready_q <= ready_d;
            ale_q   <= ale_d;
        end
    end

    assign cmp_opcode     = op_q;
    assign cmp_in0        = rs0_q;
    assign cmp_in1        = rs1_q;
    assign cmp_pc_in      = pc_q;
    assign cmp_offs_in    = offs_q;

    assign br_ready       = ready_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign flush          = flush_q;
    assign stall          = stall_q;
    assign br_ale         = ale_q;
    assign branch_cnt     = bcnt_q;
    assign taken_cnt      = tcnt_q;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl: directed vector table, randomized branches
// against a transaction-level model, reset-mid-redirect and counter saturation.
module tb_branch_seq_ctrl;

    localparam int unsigned WORD  = 32;
    localparam int unsigned OPL   = 4;
    localparam int unsigned FC    = 2;
    localparam int unsigned CNT_W = 8;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    localparam logic [OPL-1:0] CMP_EQ = 4'd0;
    localparam logic [OPL-1:0] CMP_NE = 4'd1;
    localparam logic [OPL-1:0] CMP_GE = 4'd2;
    localparam logic [OPL-1:0] CMP_B  = 4'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic             br_valid;
    logic             br_ready;
    logic [OPL-1:0]   br_opcode;
    logic [WORD-1:0]  br_rs0, br_rs1, br_pc, br_offs;
    logic [OPL-1:0]   cmp_opcode;
    logic [WORD-1:0]  cmp_in0, cmp_in1, cmp_pc_in, cmp_offs_in;
    logic             cmp_out;
    logic [WORD-1:0]  cmp_pc_out;
    logic             redirect_valid;
    logic [WORD-1:0]  redirect_pc;
    logic             redirect_ready;
    logic             flush, stall, br_ale;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_bcnt = 0;
    int exp_tcnt = 0;

    branch_seq_ctrl #(
        .WORD(WORD), .OPCODE_LEN(OPL), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_ready(br_ready), .br_opcode(br_opcode),
        .br_rs0(br_rs0), .br_rs1(br_rs1), .br_pc(br_pc), .br_offs(br_offs),
        .cmp_opcode(cmp_opcode), .cmp_in0(cmp_in0), .cmp_in1(cmp_in1),
        .cmp_pc_in(cmp_pc_in), .cmp_offs_in(cmp_offs_in),
        .cmp_out(cmp_out), .cmp_pc_out(cmp_pc_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready),
        .flush(flush), .stall(stall), .br_ale(br_ale),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic ref_taken(logic [OPL-1:0] op, logic [WORD-1:0] a, logic [WORD-1:0] b);
        case (op)
            CMP_EQ:  return a == b;
            CMP_NE:  return a != b;
            CMP_GE:  return $signed(a) >= $signed(b);
            CMP_B:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Comparator stand-in fed only from the controller's operand outputs
    always_comb begin
        cmp_out    = ref_taken(cmp_opcode, cmp_in0, cmp_in1);
        cmp_pc_out = cmp_pc_in + cmp_offs_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_branch_cnt"}, 32'(branch_cnt), 32'(exp_bcnt));
        chk({tag, "_taken_cnt"},  32'(taken_cnt),  32'(exp_tcnt));
    endtask

    // One full branch transaction; delay = cycles fetch withholds redirect_ready
    task automatic run_branch(input logic [OPL-1:0] op, input logic [WORD-1:0] rs0,
                              input logic [WORD-1:0] rs1, input logic [WORD-1:0] pc,
                              input logic [WORD-1:0] offs, input int delay, input bit hold,
                              input logic exp_taken, input logic exp_ale,
                              input logic [WORD-1:0] exp_tgt);
        chk("idle_ready", 32'(br_ready), 32'd1);
        br_valid = 1'b1; br_opcode = op; br_rs0 = rs0; br_rs1 = rs1; br_pc = pc; br_offs = offs;
        redirect_ready = 1'b0;
        step();
        if (hold) begin
            br_rs0 = ~rs0; br_pc = ~pc;
        end else begin
            br_valid = 1'b0;
        end
        chk("eval_stall",   32'(stall), 32'd1);
        chk("eval_ready",   32'(br_ready), 32'd0);
        chk("eval_cmp_op",  32'(cmp_opcode), 32'(op));
        chk("eval_cmp_in0", cmp_in0, rs0);
        chk("eval_cmp_in1", cmp_in1, rs1);
        chk("eval_cmp_pc",  cmp_pc_in, pc);
        chk("eval_cmp_off", cmp_offs_in, offs);
        chk("eval_rv",      32'(redirect_valid), 32'd0);
        if (exp_bcnt < CMAX) exp_bcnt++;
        if (exp_taken && !exp_ale && exp_tcnt < CMAX) exp_tcnt++;
        redirect_ready = (delay == 0);
        step();
        if (!exp_taken || exp_ale) begin
            chk("dec_ready", 32'(br_ready), 32'd1);
            chk("dec_stall", 32'(stall), 32'd0);
            chk("dec_rv",    32'(redirect_valid), 32'd0);
            chk("dec_flush", 32'(flush), 32'd0);
            chk("dec_ale",   32'(br_ale), 32'(exp_ale));
            br_valid = 1'b0;
            step();
            chk("ale_drop",  32'(br_ale), 32'd0);
            chk("nt_ready",  32'(br_ready), 32'd1);
        end else begin
            chk("rd_rv",    32'(redirect_valid), 32'd1);
            chk("rd_pc",    redirect_pc, exp_tgt);
            chk("rd_flush", 32'(flush), 32'd1);
            chk("rd_stall", 32'(stall), 32'd1);
            chk("rd_ale",   32'(br_ale), 32'd0);
            chk("rd_ready", 32'(br_ready), 32'd0);
            for (int i = 0; i < delay; i++) begin
                redirect_ready = 1'b0;
                step();
                chk("bp_rv",    32'(redirect_valid), 32'd1);
                chk("bp_pc",    redirect_pc, exp_tgt);
                chk("bp_flush", 32'(flush), 32'd1);
                chk("bp_stall", 32'(stall), 32'd1);
                chk("bp_ready", 32'(br_ready), 32'd0);
                chk("bp_cmp_in0", cmp_in0, rs0);
            end
            redirect_ready = 1'b1;
            step();
            for (int k = 0; k < int'(FC); k++) begin
                redirect_ready = 1'($urandom_range(0, 1));
                chk("fl_flush", 32'(flush), 32'd1);
                chk("fl_rv",    32'(redirect_valid), 32'd0);
                chk("fl_stall", 32'(stall), 32'd1);
                chk("fl_ready", 32'(br_ready), 32'd0);
                step();
            end
            chk("end_ready", 32'(br_ready), 32'd1);
            chk("end_flush", 32'(flush), 32'd0);
            chk("end_stall", 32'(stall), 32'd0);
            chk("end_cmp_pc", cmp_pc_in, pc);
            br_valid = 1'b0;
        end
        redirect_ready = 1'b0;
        chk_counters("txn");
    endtask

    typedef struct {
        logic [OPL-1:0]  op;
        logic [WORD-1:0] rs0, rs1, pc, offs;
        int              delay;
        bit              hold;
        logic            exp_taken;
        logic            exp_ale;
        logic [WORD-1:0] exp_tgt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{CMP_EQ, 32'd5, 32'd6, 32'h1C000100, 32'h20, 0, 1'b0, 1'b0, 1'b0, 32'h1C000120};
        vecs[1] = '{CMP_GE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1C000000, 32'h40, 0, 1'b0, 1'b1, 1'b0, 32'h1C000040};
        vecs[2] = '{CMP_B,  32'd0, 32'd0, 32'h1C001000, 32'hFFFFFFF0, 4, 1'b1, 1'b1, 1'b0, 32'h1C000FF0};
        vecs[3] = '{CMP_NE, 32'd1, 32'd2, 32'h1C000000, 32'h6, 0, 1'b0, 1'b1, 1'b1, 32'h1C000006};
        vecs[4] = '{CMP_EQ, 32'd7, 32'd7, 32'h1C000200, 32'h4, 1, 1'b0, 1'b1, 1'b0, 32'h1C000204};
        vecs[5] = '{4'd12,  32'd3, 32'd3, 32'h1C000300, 32'h8, 0, 1'b0, 1'b0, 1'b0, 32'h1C000308};

        rst = 1'b1; br_valid = 1'b0; br_opcode = '0; br_rs0 = '0; br_rs1 = '0;
        br_pc = '0; br_offs = '0; redirect_ready = 1'b0;
        #1;
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_rv",    32'(redirect_valid), 32'd0);
        chk("rst_rpc",   redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ale",   32'(br_ale), 32'd0);
        chk("rst_cmp0",  cmp_in0, 32'd0);
        chk_counters("rst");
        @(negedge clk); rst = 1'b0;
        step();

        foreach (vecs[i])
            run_branch(vecs[i].op, vecs[i].rs0, vecs[i].rs1, vecs[i].pc, vecs[i].offs,
                       vecs[i].delay, vecs[i].hold, vecs[i].exp_taken, vecs[i].exp_ale,
                       vecs[i].exp_tgt);

        for (int n = 0; n < 40; n++) begin
            logic [OPL-1:0]  op;
            logic [WORD-1:0] a, b, pc, offs, tgt;
            logic            tk;
            int              o;
            case ($urandom_range(0, 4))
                0: op = CMP_EQ;
                1: op = CMP_NE;
                2: op = CMP_GE;
                3: op = CMP_B;
                default: op = 4'd9;
            endcase
            a    = $urandom;
            b    = ($urandom_range(0, 1) == 1) ? a : 32'($urandom);
            pc   = 32'h1C000000 | (32'($urandom) & 32'h0000FFFC);
            o    = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 3) != 0) o = o & ~3;
            offs = 32'(o);
            tgt  = pc + offs;
            tk   = ref_taken(op, a, b);
            run_branch(op, a, b, pc, offs, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       tk, tk && (tgt[1:0] != 2'b00), tgt);
        end

        // Reset while a redirect is pending
        br_valid = 1'b1; br_opcode = CMP_B; br_pc = 32'h1C000010; br_offs = 32'h10;
        redirect_ready = 1'b0;
        step();
        br_valid = 1'b0;
        step();
        chk("pre_rst_rv", 32'(redirect_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rv",    32'(redirect_valid), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_ready", 32'(br_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        exp_bcnt = 0; exp_tcnt = 0;
        step();
        chk("post_rst_rv",    32'(redirect_valid), 32'd0);
        chk("post_rst_ready", 32'(br_ready), 32'd1);
        chk_counters("post_rst");

        // Saturate branch_cnt, then a taken branch must still count as taken
        for (int n = 0; n < CMAX; n++)
            run_branch(CMP_EQ, 32'd0, 32'd1, 32'h1C000000, 32'h8, 0, 1'b0, 1'b0, 1'b0, 32'h1C000008);
        chk("sat_pre_branch", 32'(branch_cnt), 32'h000000FF);
        run_branch(CMP_B, 32'd0, 32'd0, 32'h1C000000, 32'h80, 0, 1'b0, 1'b1, 1'b0, 32'h1C000080);
        chk("sat_branch", 32'(branch_cnt), 32'h000000FF);
        chk("sat_taken",  32'(taken_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
